// File: rtl/pll_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and the PLL / 72 MHz domain.
// master = supervisor side, slave = PLL and system side.
interface pll_supervisor_if;
  logic       locked;
  logic       clear_fault;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_count;

  modport master (
    input  locked,
    input  clear_fault,
    output pll_resetb,
    output pll_bypass,
    output sys_reset_n,
    output ready,
    output fault,
    output lock_loss_count
  );

  modport slave (
    output locked,
    output clear_fault,
    input  pll_resetb,
    input  pll_bypass,
    input  sys_reset_n,
    input  ready,
    input  fault,
    input  lock_loss_count
  );
endinterface

// File: rtl/pll_supervisor.sv
// Lock supervisor and reset sequencer for the acquisition-clock PLL, running on the reference clock.
// Pulses PLL reset, qualifies lock, releases the system reset, retries on timeout and falls back to bypass.
module pll_supervisor #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 14400,
  parameter int unsigned STABLE_CYCLES = 144,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic             clock_in,
  input  logic             reset_n,
  pll_supervisor_if.master bus
);

  localparam int unsigned MAX_HT  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_HT > STABLE_CYCLES) ? MAX_HT : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int unsigned LOSS_W  = 8;

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_DONE  = CNT_W'(STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT     = {LOSS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               sync1_q, sync1_d;
  logic               locked_s_q, locked_s_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               pll_bypass_q, pll_bypass_d;
  logic               sys_reset_n_q, sys_reset_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  assign retry_inc = retry_q + RETRY_W'(1);

  // Next state, counters and registered outputs; outputs are decoded from the next state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    loss_d        = loss_q;
    // LOCK is meaningless while the PLL is held in reset, so it is masked before the synchronizer;
    // this also flushes any stale lock before the next attempt.
    sync1_d       = bus.locked & pll_resetb_q;
    locked_s_d    = sync1_q;
    pll_resetb_d  = 1'b0;
    pll_bypass_d  = 1'b0;
    sys_reset_n_d = 1'b0;
    ready_d       = 1'b0;
    fault_d       = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STABLE: begin
        if (!locked_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_DONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s_q) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (loss_q != LOSS_SAT) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end

      ST_FAULT: begin
        if (bus.clear_fault) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end
      end

      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    unique case (state_d)
      ST_WAIT_LOCK,
      ST_STABLE: pll_resetb_d = 1'b1;
      ST_RUN: begin
        pll_resetb_d  = 1'b1;
        sys_reset_n_d = 1'b1;
        ready_d       = 1'b1;
      end
      ST_FAULT: begin
        pll_bypass_d = 1'b1;
        fault_d      = 1'b1;
      end
      default: pll_resetb_d = 1'b0;
    endcase
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      retry_q       <= '0;
      loss_q        <= '0;
      sync1_q       <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_resetb_q  <= 1'b0;
      pll_bypass_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      sync1_q       <= sync1_d;
      locked_s_q    <= locked_s_d;
      pll_resetb_q  <= pll_resetb_d;
      pll_bypass_q  <= pll_bypass_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.pll_resetb      = pll_resetb_q;
  assign bus.pll_bypass      = pll_bypass_q;
  assign bus.sys_reset_n     = sys_reset_n_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed sequencing scenarios plus random lock activity,
// every cycle compared against a timestamp-based behavioural model.
module tb_pll_supervisor;

  localparam int unsigned HOLD_C    = 4;
  localparam int unsigned TIMEOUT_C = 20;
  localparam int unsigned STABLE_C  = 8;
  localparam int unsigned RETRIES_C = 2;

  logic clk;
  logic rst_n;

  pll_supervisor_if bus ();

  pll_supervisor #(
    .HOLD_CYCLES  (HOLD_C),
    .LOCK_TIMEOUT (TIMEOUT_C),
    .STABLE_CYCLES(STABLE_C),
    .MAX_RETRIES  (RETRIES_C)
  ) dut (
    .clock_in(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at edge %0d t=%0t", tag, obs, exp, edge_n, $time);
    end
  endtask

  // Behavioural model: phase plus the edge at which it was entered; durations are elapsed-time tests.
  typedef enum {M_HOLD, M_WAIT, M_STABLE, M_RUN, M_FAULT} mph_t;
  mph_t m_ph     = M_HOLD;
  int   m_now    = 0;
  int   m_since  = 0;
  int   m_tries  = 0;
  int   m_losses = 0;
  bit   m_sync[$] = '{1'b0, 1'b0};

  function automatic bit m_resetb();
    return (m_ph == M_WAIT) || (m_ph == M_STABLE) || (m_ph == M_RUN);
  endfunction

  task automatic m_enter(input mph_t p);
    m_ph    = p;
    m_since = m_now;
  endtask

  task automatic model_edge(input bit rn, input bit lk, input bit cf);
    bit ls;
    m_now++;
    if (!rn) begin
      m_enter(M_HOLD);
      m_tries  = 0;
      m_losses = 0;
      m_sync   = '{1'b0, 1'b0};
    end else begin
      ls = m_sync[0];
      void'(m_sync.pop_front());
      m_sync.push_back(lk && m_resetb());
      case (m_ph)
        M_HOLD:   if (m_now - m_since == HOLD_C) m_enter(M_WAIT);
        M_WAIT: begin
          if (ls) m_enter(M_STABLE);
          else if (m_now - m_since == TIMEOUT_C) begin
            m_tries++;
            m_enter((m_tries == RETRIES_C) ? M_FAULT : M_HOLD);
          end
        end
        M_STABLE: begin
          if (!ls) m_enter(M_WAIT);
          else if (m_now - m_since == STABLE_C + 1) begin
            m_tries = 0;
            m_enter(M_RUN);
          end
        end
        M_RUN: begin
          if (!ls) begin
            if (m_losses < 255) m_losses++;
            m_enter(M_HOLD);
          end
        end
        M_FAULT: begin
          if (cf) begin
            m_tries = 0;
            m_enter(M_HOLD);
          end
        end
        default: m_enter(M_HOLD);
      endcase
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs just after the edge.
  task automatic tick(input bit rn, input bit lk, input bit cf);
    rst_n           = rn;
    bus.locked      = lk;
    bus.clear_fault = cf;
    model_edge(rn, lk, cf);
    @(posedge clk);
    #1;
    if (!rn) edge_n = 0;
    else edge_n++;
    check_eq("pll_resetb",      32'(bus.pll_resetb),      32'(m_resetb()));
    check_eq("pll_bypass",      32'(bus.pll_bypass),      32'(m_ph == M_FAULT));
    check_eq("sys_reset_n",     32'(bus.sys_reset_n),     32'(m_ph == M_RUN));
    check_eq("ready",           32'(bus.ready),           32'(m_ph == M_RUN));
    check_eq("fault",           32'(bus.fault),           32'(m_ph == M_FAULT));
    check_eq("lock_loss_count", 32'(bus.lock_loss_count), 32'(m_losses));
  endtask

  task automatic wait_ready(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.ready; i++) tick(1'b1, 1'b1, 1'b0);
    check_eq(tag, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int rb_edge, rel_edge, fault_edge, d, lost, hold_len, run_left;
    bit lk_r;

    rst_n           = 1'b0;
    bus.locked      = 1'b0;
    bus.clear_fault = 1'b0;

    // Reset release with locked tied high.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("rst_resetb", 32'(bus.pll_resetb), 32'd0);
    check_eq("rst_sysrst", 32'(bus.sys_reset_n), 32'd0);
    rb_edge  = -1;
    rel_edge = -1;
    for (int i = 0; i < 40 && rel_edge < 0; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (rb_edge < 0 && bus.pll_resetb) rb_edge = edge_n;
      if (bus.sys_reset_n) rel_edge = edge_n;
    end
    check_eq("resetb_rise_edge", 32'(rb_edge), 32'd4);
    check_eq("release_edge", 32'(rel_edge), 32'd16);
    check_eq("ready_at_release", 32'(bus.ready), 32'd1);
    check_eq("fault_quiet", 32'(bus.fault), 32'd0);

    // Three lock losses in RUN.
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      d    = edge_n;
      lost = -1;
      for (int i = 0; i < 10 && lost < 0; i++) begin
        tick(1'b1, 1'b0, 1'b0);
        if (!bus.sys_reset_n) lost = edge_n - d;
      end
      check_eq("loss_latency", 32'(lost), 32'd3);
      hold_len = 0;
      for (int i = 0; i < 20 && !bus.pll_resetb; i++) begin
        tick(1'b1, 1'b0, 1'b0);
        hold_len++;
      end
      check_eq("hold_len_after_loss", 32'(hold_len), 32'd4);
      wait_ready("relock_after_loss", 60);
    end
    check_eq("loss_count_3", 32'(bus.lock_loss_count), 32'd3);

    // One-cycle lock glitch five cycles into STABLE.
    tick(1'b0, 1'b1, 1'b0);
    rel_edge = -1;
    for (int i = 0; i < 60 && rel_edge < 0; i++) begin
      tick(1'b1, (edge_n + 1 != 13), 1'b0);
      if (bus.sys_reset_n) rel_edge = edge_n;
    end
    check_eq("release_after_glitch", 32'(rel_edge), 32'd25);

    // Locked held low: two timeouts lead to FAULT; clear_fault in WAIT_LOCK is ignored.
    tick(1'b0, 1'b0, 1'b0);
    fault_edge = -1;
    for (int i = 0; i < 80 && fault_edge < 0; i++) begin
      tick(1'b1, 1'b0, (edge_n + 1 == 10));
      if (bus.fault) fault_edge = edge_n;
    end
    check_eq("fault_edge", 32'(fault_edge), 32'd48);
    check_eq("fault_bypass", 32'(bus.pll_bypass), 32'd1);
    check_eq("fault_resetb", 32'(bus.pll_resetb), 32'd0);
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    check_eq("fault_ignores_lock", 32'(bus.fault), 32'd1);

    // Recovery, then saturation of the lock-loss counter.
    tick(1'b1, 1'b1, 1'b1);
    check_eq("clear_fault_fault", 32'(bus.fault), 32'd0);
    check_eq("clear_fault_bypass", 32'(bus.pll_bypass), 32'd0);
    wait_ready("recover_to_run", 60);
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 10 && bus.ready; i++) tick(1'b1, 1'b0, 1'b0);
      check_eq("forced_loss", 32'(bus.ready), 32'd0);
      wait_ready("forced_relock", 60);
      if (k == 254) check_eq("loss_count_255", 32'(bus.lock_loss_count), 32'd255);
    end
    check_eq("loss_count_sat", 32'(bus.lock_loss_count), 32'd255);

    // Reset mid-STABLE.
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (9) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("rst_stable_loss", 32'(bus.lock_loss_count), 32'd0);
    check_eq("rst_stable_resetb", 32'(bus.pll_resetb), 32'd0);

    // Reset mid-FAULT.
    for (int i = 0; i < 80 && !bus.fault; i++) tick(1'b1, 1'b0, 1'b0);
    check_eq("reach_fault", 32'(bus.fault), 32'd1);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("rst_fault_fault", 32'(bus.fault), 32'd0);
    check_eq("rst_fault_bypass", 32'(bus.pll_bypass), 32'd0);
    check_eq("rst_fault_loss", 32'(bus.lock_loss_count), 32'd0);

    // Random lock activity with occasional clear_fault and reset.
    run_left = 0;
    lk_r     = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        lk_r     = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 40);
      end
      run_left--;
      tick(($urandom_range(0, 499) != 0), lk_r, ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
